// File: rtl/usb_dfu_pkg.sv
// usb_dfu_pkg: DFU state codes, boot cause encodings and boot FSM states shared by the boot controller
package usb_dfu_pkg;
  localparam logic [7:0] APP_IDLE = 8'd0;
  localparam logic [7:0] APP_DETACH = 8'd1;
  localparam logic [7:0] DFU_IDLE = 8'd2;
  localparam logic [7:0] DFU_MANIFEST_WAIT_RESET = 8'd8;
  localparam logic [7:0] DFU_ERROR = 8'd10;
  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_NO_HOST = 2'd1;
  localparam logic [1:0] CAUSE_HOST_LOST = 2'd2;
  localparam logic [1:0] CAUSE_DFU = 2'd3;
  localparam logic [1:0] ST_WAIT_HOST = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_DELAY = 2'd2;
  localparam logic [1:0] ST_BOOT = 2'd3;
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hffff) ? v + 16'd1 : v;
  endfunction
endpackage

// File: rtl/usb_sof_qualifier.sv
// usb_sof_qualifier: counts consecutive sequential SOFs and milliseconds since the last SOF
module usb_sof_qualifier import usb_dfu_pkg::*; #(
  parameter int SOF_QUALIFY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sof_valid,
  input  logic [10:0] frame_index,
  input  logic        tick,
  output logic        qualified,
  output logic [15:0] lost_ms
);
  localparam logic [15:0] QUAL = 16'(SOF_QUALIFY);
  logic [15:0] sof_run, run_inc, run_nxt, ms_since_sof;
  logic [10:0] last_frame;
  // next-cycle run length and SOF age, exported so the FSM acts in the same cycle
  always_comb begin
    run_inc = sof_run + 16'd1;
    run_nxt = !sof_valid ? sof_run :
              (sof_run == 16'd0 || frame_index == last_frame + 11'd1) ? (run_inc > QUAL ? QUAL : run_inc) : 16'd1;
    lost_ms = sof_valid ? 16'd0 : sat_inc(ms_since_sof, tick);
    qualified = run_nxt >= QUAL;
  end
  // qualifier state registers
  always_ff @(posedge clk)
    if (!reset) begin
      sof_run <= 16'd0;
      last_frame <= 11'd0;
      ms_since_sof <= 16'd0;
    end else begin
      sof_run <= run_nxt;
      ms_since_sof <= lost_ms;
      last_frame <= sof_valid ? frame_index : last_frame;
    end
endmodule

// File: rtl/usb_dfu_boot_ctrl.sv
// usb_dfu_boot_ctrl: decides when the bootloader warm-boots into the user image
module usb_dfu_boot_ctrl import usb_dfu_pkg::*; #(
  parameter int CLK_HZ = 48000000,
  parameter int HOST_WAIT_MS = 3000,
  parameter int HOST_LOST_MS = 100,
  parameter int SOF_QUALIFY = 4,
  parameter int REBOOT_DELAY_MS = 10,
  parameter logic [1:0] USER_IMAGE = 2'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sof_valid,
  input  logic [10:0] frame_index,
  input  logic [7:0]  dfu_state,
  input  logic        boot_inhibit,
  output logic        host_present,
  output logic        boot,
  output logic [1:0]  boot_image,
  output logic [1:0]  boot_cause
);
  localparam int DIV = CLK_HZ / 1000;
  localparam int TW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(DIV > 0 ? DIV - 1 : 0);
  localparam logic [15:0] WAIT_MS = 16'(HOST_WAIT_MS);
  localparam logic [15:0] LOST_MS = 16'(HOST_LOST_MS);
  localparam logic [15:0] DELAY_MS = 16'(REBOOT_DELAY_MS);
  logic [TW-1:0] tcnt;
  logic tick, qualified;
  logic [15:0] elapsed, elapsed_nxt, dly, dly_nxt, lost_ms;
  logic [1:0] state, state_nxt, cause_nxt;
  assign tick = tcnt == '0;
  assign boot = state == ST_BOOT;
  assign boot_image = boot ? USER_IMAGE : 2'd0;
  usb_sof_qualifier #(.SOF_QUALIFY(SOF_QUALIFY)) u_sof (
    .clk(clk),
    .reset(reset),
    .sof_valid(sof_valid),
    .frame_index(frame_index),
    .tick(tick),
    .qualified(qualified),
    .lost_ms(lost_ms)
  );
  // boot FSM evaluated on the already-updated counters; inhibit only blocks DELAY/BOOT entry
  always_comb begin
    elapsed_nxt = sat_inc(elapsed, tick);
    dly_nxt = sat_inc(dly, tick);
    state_nxt = state;
    cause_nxt = boot_cause;
    case (state)
      ST_WAIT_HOST:
        if (qualified) state_nxt = ST_PRESENT;
        else if (!boot_inhibit && elapsed_nxt >= WAIT_MS) begin
          state_nxt = ST_BOOT;
          cause_nxt = CAUSE_NO_HOST;
        end
      ST_PRESENT:
        if (!boot_inhibit && (dfu_state == DFU_MANIFEST_WAIT_RESET || dfu_state == APP_DETACH)) begin
          state_nxt = ST_DELAY;
          cause_nxt = CAUSE_DFU;
        end else if (!boot_inhibit && lost_ms >= LOST_MS) begin
          state_nxt = ST_BOOT;
          cause_nxt = CAUSE_HOST_LOST;
        end
      ST_DELAY: if (!boot_inhibit && dly_nxt >= DELAY_MS) state_nxt = ST_BOOT;
      default: ;
    endcase
  end
  // free-running ms divider, elapsed/delay timers and FSM state
  always_ff @(posedge clk)
    if (!reset) begin
      tcnt <= RELOAD;
      elapsed <= 16'd0;
      dly <= 16'd0;
      state <= ST_WAIT_HOST;
      boot_cause <= CAUSE_NONE;
      host_present <= 1'b0;
    end else begin
      tcnt <= tick ? RELOAD : tcnt - TW'(1);
      elapsed <= elapsed_nxt;
      dly <= state == ST_DELAY ? dly_nxt : 16'd0;
      state <= state_nxt;
      boot_cause <= cause_nxt;
      host_present <= state_nxt == ST_PRESENT || (state_nxt == ST_DELAY && lost_ms < LOST_MS);
    end
endmodule
